instruction_fetch_stage: RTL
============================

Name: instruction_fetch_stage

Overview:
Instruction-fetch (IF) stage that produces the Instruction_IF / PC_Plus_4_IF pair consumed by the IF/ID pipeline register. It owns the PC and drives a single-outstanding req/ready handshake to instruction memory. It accepts a stall from the hazard unit and a branch/jump redirect from ID. It is the producer end of the IF→ID interface.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).
NOP_WORD, 32'h0000_0000, value driven on Instruction_IF when empty or flushed (sll $0,$0,0).

Ports:
Clk  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-high reset.
Stall_IF  input  1  hazard unit: ID is not consuming this cycle; hold outputs.
Branch_Taken_ID  input  1  redirect request from ID (single-cycle pulse).
Branch_Target_ID  input  32  redirect target; bits [1:0] ignored and forced to 0.
Imem_Req  output  1  fetch request to instruction memory.
Imem_Addr  output  32  fetch address; stable while Imem_Req=1 and Imem_Ready=0.
Imem_Ready  input  1  memory done; Imem_Rdata valid in the same cycle.
Imem_Rdata  input  32  fetched instruction word.
Instruction_IF  output  32  fetched instruction to the IF/ID register.
PC_Plus_4_IF  output  32  address of Instruction_IF plus 4.
Valid_IF  output  1  Instruction_IF/PC_Plus_4_IF hold a real instruction.

Behaviour:
- Clocking: one clock, Clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE, PC=RESET_PC, Imem_Addr=RESET_PC, Imem_Req=0, Valid_IF=0, Instruction_IF=NOP_WORD, PC_Plus_4_IF=0, skid empty.
- Output consumption: the output slot is consumed at any edge where Valid_IF=1 and Stall_IF=0. Define slot_free = !Valid_IF || !Stall_IF.
- Handshake: Imem_Req=1 in FETCH and SQUASH only. Once Imem_Req is asserted, it stays asserted with Imem_Addr unchanged until an edge with Imem_Ready=1. Imem_Ready is ignored while Imem_Req=0.
- Throughput and latency: with a zero-wait memory, one instruction per cycle. Imem_Rdata appears on Instruction_IF one cycle after the Imem_Ready cycle.
- IDLE: the first edge after Reset deasserts goes to FETCH, with Imem_Addr=PC.
- FETCH, on Imem_Ready=1 with no redirect:
  - If slot_free: Instruction_IF<=Imem_Rdata, PC_Plus_4_IF<=Imem_Addr+4, Valid_IF<=1, PC<=Imem_Addr+4, Imem_Addr<=Imem_Addr+4. Stay in FETCH.
  - If !slot_free: load Imem_Rdata and Imem_Addr+4 into the skid buffer, set PC<=Imem_Addr+4, go to HOLD.
- FETCH with Imem_Ready=0: hold all outputs, except that Valid_IF<=0 if the slot is consumed.
- HOLD: Imem_Req=0. On Stall_IF=0, move the skid contents to the outputs (Valid_IF stays 1), set Imem_Addr<=PC, go to FETCH.
- Redirect (Branch_Taken_ID=1 at an edge): takes priority over stall and fetch completion.
  - Always: Valid_IF<=0, Instruction_IF<=NOP_WORD, PC_Plus_4_IF<=0, skid cleared, PC<={Branch_Target_ID[31:2],2'b00}.
  - From FETCH with Imem_Ready=0: go to SQUASH; Imem_Addr is held at the old address.
  - From FETCH with Imem_Ready=1, from HOLD, or from IDLE: go to FETCH with Imem_Addr=target; returned data is dropped.
- SQUASH: the outstanding request completes and its data is discarded. On Imem_Ready: Imem_Addr<=PC, go to FETCH. A further redirect while in SQUASH updates PC only.
- Arithmetic: PC+4 is modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- Reset mid-operation: immediately forces all reset values, including Imem_Req=0. Any in-flight memory response is not tracked.

Decomposition:
- Shared package: state encoding (IDLE, FETCH, HOLD, SQUASH as 2-bit localparams), NOP_WORD, and the default RESET_PC, shared with the hazard unit and the IF/ID register.
- One sub-module: fetch_skid_buffer, a one-entry {instr, pc_plus_4, full} holding register with load, unload and clear.

Test Plan:
1. Reset release, zero-wait memory returning addr-tagged words → Imem_Addr 0x0,0x4,0x8 on consecutive cycles; PC_Plus_4_IF 0x4,0x8,0xC; Valid_IF=1 from the second cycle after IDLE.
2. Memory with 2 wait states → Imem_Addr stable for 3 cycles per request; Valid_IF drops between instructions; no duplicate or skipped PCs.
3. Stall_IF=1 for 3 cycles while a fetch completes → outputs frozen, skid full, Imem_Req=0 in HOLD; on release the skid word appears next, then fetch resumes at the correct PC.
4. Redirect to 0x0000_0103 while a request is outstanding (Imem_Ready=0) → SQUASH; the old-address response is dropped; next Imem_Addr=0x0000_0100; Valid_IF=0 until that word returns.
5. Branch_Taken_ID and Stall_IF high on the same edge with Valid_IF=1 → flush wins: Valid_IF=0, Instruction_IF=0x00000000, next fetch at the target.
6. Reset asserted mid-request in FETCH and in HOLD → Imem_Req=0 and Valid_IF=0 asynchronously; after release Imem_Addr=RESET_PC; PC wrap from 0xFFFF_FFFC gives PC_Plus_4_IF=0x0.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage, the hazard unit and
// the IF/ID pipeline register: state encoding, fetch word layout, defaults.
package instruction_fetch_stage_pkg;

    // Raw 2-bit state codes, kept as localparams so that other blocks
    // (hazard unit, debug taps) can decode the fetch state directly.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_SQUASH = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        HOLD   = ST_HOLD,
        SQUASH = ST_SQUASH
    } if_state_t;

    // sll $0,$0,0 encodes as all zeros.
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One instruction together with the address that follows it.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_4;
    } fetch_word_t;

    // Instruction addresses are always word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Single-outstanding request/ready bus between the fetch stage and
// instruction memory. Rdata is valid in the same cycle as Ready.
interface instruction_fetch_stage_if;

    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ready;
    logic [31:0] Imem_Rdata;

    // Fetch stage side: issues requests, receives data.
    modport master (
        output Imem_Req,
        output Imem_Addr,
        input  Imem_Ready,
        input  Imem_Rdata
    );

    // Memory side: accepts requests, returns data.
    modport slave (
        input  Imem_Req,
        input  Imem_Addr,
        output Imem_Ready,
        output Imem_Rdata
    );

endinterface

// File: rtl/instruction_fetch_stage_skid.sv
// One-entry holding register for a word that returned from memory while
// the IF/ID slot was still occupied by a stalled instruction.
module fetch_skid_buffer
    import instruction_fetch_stage_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  fetch_word_t load_word,
    output fetch_word_t word,
    output logic        full
);

    // Capture on load, empty on unload or flush; clear wins over everything.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (Reset) begin
            // NOTE: the data field is reset too (only one entry, cheap) so a
            // flushed or empty skid never exposes X to the output mux.
            word <= '0;
            full <= 1'b0;
        end else if (clear) begin
            word <= '0;
            full <= 1'b0;
        end else if (load) begin
            word <= load_word;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding fetch on
// the imem bus, and presents Instruction_IF / PC_Plus_4_IF / Valid_IF to
// the IF/ID register. Honours stall from the hazard unit and redirects
// from ID; a redirect always flushes the output slot and the skid.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
)(
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               Stall_IF,
    input  logic                               Branch_Taken_ID,
    input  logic [31:0]                        Branch_Target_ID,
    instruction_fetch_stage_if.master          imem,
    output logic [31:0]                        Instruction_IF,
    output logic [31:0]                        PC_Plus_4_IF,
    output logic                               Valid_IF
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    fetch_word_t out_q, out_d;

    logic        skid_load, skid_unload, skid_clear;
    fetch_word_t skid_word;
    logic        skid_full;

    logic        slot_free;
    logic        slot_consumed;
    logic [31:0] fetch_pc_plus_4;
    logic [31:0] redirect_pc;

    assign slot_free       = !valid_q || !Stall_IF;
    assign slot_consumed   = valid_q && !Stall_IF;
    assign fetch_pc_plus_4 = addr_q + 32'd4;   // wraps modulo 2^32
    assign redirect_pc     = word_align(Branch_Target_ID);

    fetch_skid_buffer u_skid (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .load_word ('{instr: imem.Imem_Rdata, pc_plus_4: fetch_pc_plus_4}),
        .word      (skid_word),
        .full      (skid_full)
    );

    // Next-state, PC, fetch address and output-slot decisions.
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // left one unassigned would infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        out_d       = out_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (Branch_Taken_ID) begin
            // Redirect beats stall and fetch completion.
            valid_d    = 1'b0;
            out_d      = '{instr: NOP_WORD, pc_plus_4: 32'h0};
            skid_clear = 1'b1;
            pc_d       = redirect_pc;
            if ((state_q == FETCH || state_q == SQUASH) && !imem.Imem_Ready) begin
                // Request still in flight: address must stay put until it completes.
                state_d = SQUASH;
            end else begin
                state_d = FETCH;
                addr_d  = redirect_pc;
            end
        end else begin
            if (slot_consumed) begin
                valid_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    addr_d  = pc_q;
                end
                FETCH: begin
                    if (imem.Imem_Ready) begin
                        pc_d = fetch_pc_plus_4;
                        if (slot_free) begin
                            out_d   = '{instr: imem.Imem_Rdata, pc_plus_4: fetch_pc_plus_4};
                            valid_d = 1'b1;
                            addr_d  = fetch_pc_plus_4;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!Stall_IF && skid_full) begin
                        out_d       = skid_word;
                        valid_d     = 1'b1;
                        skid_unload = 1'b1;
                        addr_d      = pc_q;
                        state_d     = FETCH;
                    end
                end
                SQUASH: begin
                    // Stale response is discarded; restart at the redirected PC.
                    if (imem.Imem_Ready) begin
                        addr_d  = pc_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, PC, fetch address and IF/ID output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            out_q   <= '{instr: NOP_WORD, pc_plus_4: 32'h0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    // A request is outstanding only while fetching or draining a squashed fetch.
    assign imem.Imem_Req  = (state_q == FETCH) || (state_q == SQUASH);
    assign imem.Imem_Addr = addr_q;

    assign Instruction_IF = out_q.instr;
    assign PC_Plus_4_IF   = out_q.pc_plus_4;
    assign Valid_IF       = valid_q;

endmodule
